draw_card_bank: RTL and testbench
=================================

DRAW_CARD_BANK -- requirements
Module: draw_card_bank

Interface
REQ-001 Parameter N_CARDS, default 4, number of cards drawn (legal range 1..16).
REQ-002 Parameter CARD_W, default 64, card width in pixels (8 bits).
REQ-003 Parameter CARD_H, default 96, card height in pixels (9 bits).
REQ-004 Parameter COVERED_COLOR, default 12'h0AA, RGB of a face-down card.
REQ-005 Parameter BORDER_COLOR, default 12'hFFF, RGB of the card frame; used only with the border option.
REQ-006 Port pclk, input, 1, the single clock; all state is clocked on its rising edge.
REQ-007 Port rst_n, input, 1, reset; asynchronous and active-low.
REQ-008 Port vga_in, input, VGA_BUS_SIZE, timing and background pixel (hs, vs, hblnk, vblnk, hcount, vcount, rgb).
REQ-009 Port vga_out, output, VGA_BUS_SIZE, the same bus delayed one cycle, with the card pixel substituted.
REQ-010 Port rd_req, output, 1, request to read the card word at rd_idx from the register file.
REQ-011 Port rd_idx, output, IDX_W = max(1, clog2(N_CARDS)), card index being fetched.
REQ-012 Port rd_valid, input, 1, rd_card and rd_pos are valid for rd_idx.
REQ-013 Port rd_card, input, 14, card word: [1:0] state (x0 inactive, 01 face-down, 11 face-up); [13:2] RGB, r:g:b from MSB to LSB.
REQ-014 Port rd_pos, input, 20, card origin: [19:10] y, [9:0] x.
REQ-015 Port sync_done, output, 1, one-cycle pulse when a freshly loaded bank becomes active.
REQ-016 Port load_miss, output, 1, one-cycle pulse when a load is aborted.

Function
REQ-017 Two banks of N_CARDS entries SHALL exist: an active bank, used for drawing, and a shadow bank, used for loading.
REQ-018 Load FSM states SHALL be IDLE, REQ, WAIT and COMMIT.
REQ-019 IDLE->REQ SHALL occur on a vblnk_in rising edge, detected against the registered vblnk; rd_idx is set to 0.
REQ-020 In REQ, rd_req SHALL be 1 for exactly one cycle, after which the FSM moves to WAIT.
REQ-021 In WAIT on rd_valid=1, rd_card and rd_pos SHALL be written to shadow[rd_idx].
REQ-022 After that write, the FSM SHALL go to COMMIT if rd_idx = N_CARDS-1; otherwise it increments rd_idx and returns to REQ.
REQ-023 rd_valid SHALL be accepted in the same cycle as rd_req or in any later cycle; rd_valid outside WAIT or REQ is ignored.
REQ-024 COMMIT SHALL copy the shadow bank into the active bank in one cycle, pulse sync_done in that cycle, and return to IDLE.
REQ-025 If vblnk_in falls while the FSM is in REQ or WAIT, the FSM SHALL go to IDLE, pulse load_miss, and leave the active bank unchanged.
REQ-026 A vblnk rising edge seen outside IDLE SHALL be ignored.
REQ-027 Card i hits when state[0]=1, x<=hcount_in<x+CARD_W, and y<=vcount_in<y+CARD_H.
REQ-028 Hit comparisons SHALL be done at 11-bit width, so x+CARD_W does not wrap.
REQ-029 On overlapping hits the lowest index SHALL win.
REQ-030 The output pixel SHALL be the winning card's RGB if state[1]=1, else COVERED_COLOR; with no hit it SHALL be rgb_in.
REQ-031 Latency SHALL be exactly 1 cycle for every vga_out field.
REQ-032 Changes to the active bank SHALL take effect on the pixel computed in the cycle after COMMIT.

Reset
REQ-033 Asserting rst_n=0 SHALL immediately clear all vga_out fields, rd_req, rd_idx, sync_done, load_miss, both banks and the edge register to 0, and put the FSM in IDLE.
REQ-034 Reset in the middle of a load SHALL discard the load without a load_miss pulse.
REQ-035 Release of rst_n SHALL be synchronous to pclk, with the first state update on the following pclk edge.

Configuration
REQ-036 With DRAW_CARD_BORDER_EN defined, a hit pixel on the first or last row or column of a card SHALL output BORDER_COLOR, regardless of face state.
REQ-037 Without DRAW_CARD_BORDER_EN, no border logic SHALL exist and the pixel is exactly as in REQ-030.

Structure
REQ-038 The shared package SHALL hold the card word field positions, the state encodings, COVERED_COLOR and BORDER_COLOR defaults, and VGA_BUS_SIZE with its field offsets.
REQ-039 One sub-module, card_hit, SHALL be instantiated N_CARDS times; it is combinational, takes a bank entry, hcount, vcount, CARD_W and CARD_H, and outputs hit and edge flags.

Verification
REQ-040 Scenario: N_CARDS=4; load card 0 = {RGB F00, 11} at pos (y=100, x=200). Required: pixel (250,120) = F00 one cycle later; pixel (199,120) = rgb_in.
REQ-041 Scenario: card 1 = 14'h0001 (face-down) at (0,0). Required: pixel (10,10) = 0AA; with state 00, pixel (10,10) = rgb_in.
REQ-042 Scenario: cards 0 and 2 overlap at (300,300). Required: card 0's RGB is output.
REQ-043 Scenario: rd_valid delayed 5 cycles per word. Required: sync_done fires exactly once after 4 words, and the active bank updates on the cycle after COMMIT.
REQ-044 Scenario: vblnk_in falls after 2 of 4 words. Required: load_miss pulse, no sync_done, old image retained.
REQ-045 Scenario: rst_n low mid-WAIT. Required: all outputs 0 immediately; after release, the next vblank performs a normal load. With DRAW_CARD_BORDER_EN defined, pixel (200,100) of card 0 = FFF.

Source files
------------

// File: rtl/draw_card_bank_pkg.sv
// rtl/draw_card_bank_pkg.sv - shared field layout, encodings and colours for draw_card_bank
package draw_card_bank_pkg;

    // VGA bus layout, LSB first: rgb, vcount, hcount, vblnk, hblnk, vs, hs
    localparam int VGA_BUS_SIZE = 38;
    localparam int CNT_W        = 11;
    localparam int RGB_W        = 12;
    localparam int RGB_LSB      = 0;
    localparam int VCOUNT_LSB   = 12;
    localparam int HCOUNT_LSB   = 23;
    localparam int VBLNK_BIT    = 34;
    localparam int HBLNK_BIT    = 35;
    localparam int VS_BIT       = 36;
    localparam int HS_BIT       = 37;

    localparam int CARD_WORD_W     = 14;
    localparam int CARD_ACTIVE_BIT = 0;
    localparam int CARD_FACE_BIT   = 1;
    localparam int CARD_RGB_LSB    = 2;
    localparam int POS_W           = 20;
    localparam int POS_X_LSB       = 0;
    localparam int POS_Y_LSB       = 10;
    localparam int POS_FIELD_W     = 10;

    localparam logic [1:0] CARD_INACTIVE = 2'b00;
    localparam logic [1:0] CARD_DOWN     = 2'b01;
    localparam logic [1:0] CARD_UP       = 2'b11;

    localparam logic [11:0] COVERED_COLOR_DEF = 12'h0AA;
    localparam logic [11:0] BORDER_COLOR_DEF  = 12'hFFF;

    typedef struct packed {
        logic [POS_W-1:0]       pos;
        logic [CARD_WORD_W-1:0] card;
    } card_entry_t;

endpackage

// File: rtl/draw_card_bank_card_hit.sv
// rtl/draw_card_bank_card_hit.sv - card_hit: combinational rectangle test for one card (edge flag with DRAW_CARD_BORDER_EN)
module card_hit
    import draw_card_bank_pkg::*;
#(
    parameter int CARD_W = 64,
    parameter int CARD_H = 96
)(
    input  logic             enable,
    input  logic [POS_W-1:0] pos,
    input  logic [CNT_W-1:0] hcount,
    input  logic [CNT_W-1:0] vcount,
    output logic             hit
`ifdef DRAW_CARD_BORDER_EN
    ,
    output logic             on_edge
`endif
);

    logic [CNT_W-1:0] x0, y0, x1, y1;

    // One bit wider than the 10-bit origin so the far edge never wraps
    assign x0 = {1'b0, pos[POS_X_LSB +: POS_FIELD_W]};
    assign y0 = {1'b0, pos[POS_Y_LSB +: POS_FIELD_W]};
    assign x1 = x0 + CNT_W'(CARD_W);
    assign y1 = y0 + CNT_W'(CARD_H);

    assign hit = enable && (hcount >= x0) && (hcount < x1)
                        && (vcount >= y0) && (vcount < y1);

`ifdef DRAW_CARD_BORDER_EN
    assign on_edge = hit && ((hcount == x0) || (hcount == x1 - 11'd1)
                          || (vcount == y0) || (vcount == y1 - 11'd1));
`endif

endmodule

// File: rtl/draw_card_bank.sv
// rtl/draw_card_bank.sv - double-buffered card bank overlay on a VGA stream; DRAW_CARD_BORDER_EN adds card frames
module draw_card_bank
    import draw_card_bank_pkg::*;
#(
    parameter int          N_CARDS       = 4,
    parameter int          CARD_W        = 64,
    parameter int          CARD_H        = 96,
    parameter logic [11:0] COVERED_COLOR = COVERED_COLOR_DEF,
    parameter logic [11:0] BORDER_COLOR  = BORDER_COLOR_DEF,
    localparam int         IDX_W         = (N_CARDS > 1) ? $clog2(N_CARDS) : 1
)(
    input  logic                    pclk,
    input  logic                    rst_n,
    input  logic [VGA_BUS_SIZE-1:0] vga_in,
    output logic [VGA_BUS_SIZE-1:0] vga_out,
    output logic                    rd_req,
    output logic [IDX_W-1:0]        rd_idx,
    input  logic                    rd_valid,
    input  logic [CARD_WORD_W-1:0]  rd_card,
    input  logic [POS_W-1:0]        rd_pos,
    output logic                    sync_done,
    output logic                    load_miss
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CARDS - 1);

    logic [1:0]  state;
    logic        vblnk_q;
    card_entry_t act_bank [N_CARDS];
    card_entry_t shd_bank [N_CARDS];

    logic             vblnk_in;
    logic             vblnk_rise, vblnk_fall;
    logic [CNT_W-1:0] hcount_in, vcount_in;
    logic [RGB_W-1:0] rgb_in, pixel;

    assign vblnk_in   = vga_in[VBLNK_BIT];
    assign hcount_in  = vga_in[HCOUNT_LSB +: CNT_W];
    assign vcount_in  = vga_in[VCOUNT_LSB +: CNT_W];
    assign rgb_in     = vga_in[RGB_LSB +: RGB_W];
    assign vblnk_rise = vblnk_in && !vblnk_q;
    assign vblnk_fall = !vblnk_in && vblnk_q;

    assign rd_req    = (state == S_REQ);
    assign sync_done = (state == S_COMMIT);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rd_idx    <= '0;
            vblnk_q   <= 1'b0;
            load_miss <= 1'b0;
            vga_out   <= '0;
            for (int i = 0; i < N_CARDS; i++) begin
                act_bank[i] <= '0;
                shd_bank[i] <= '0;
            end
        end else begin
            vblnk_q   <= vblnk_in;
            load_miss <= 1'b0;
            vga_out   <= {vga_in[VGA_BUS_SIZE-1:RGB_W], pixel};
            case (state)
                S_IDLE: begin
                    if (vblnk_rise) begin
                        state  <= S_REQ;
                        rd_idx <= '0;
                    end
                end
                S_REQ, S_WAIT: begin
                    // Losing the blanking window wins over a late word
                    if (vblnk_fall) begin
                        state     <= S_IDLE;
                        load_miss <= 1'b1;
                    end else if (rd_valid) begin
                        shd_bank[rd_idx] <= '{pos: rd_pos, card: rd_card};
                        if (rd_idx == LAST_IDX) begin
                            state <= S_COMMIT;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                            state  <= S_REQ;
                        end
                    end else if (state == S_REQ) begin
                        state <= S_WAIT;
                    end
                end
                S_COMMIT: begin
                    act_bank <= shd_bank;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [N_CARDS-1:0] hit_vec;
`ifdef DRAW_CARD_BORDER_EN
    logic [N_CARDS-1:0] edge_vec;
`endif

    for (genvar g = 0; g < N_CARDS; g++) begin : g_hit
        card_hit #(
            .CARD_W (CARD_W),
            .CARD_H (CARD_H)
        ) u_card_hit (
            .enable  (act_bank[g].card[CARD_ACTIVE_BIT]),
            .pos     (act_bank[g].pos),
            .hcount  (hcount_in),
            .vcount  (vcount_in),
            .hit     (hit_vec[g])
`ifdef DRAW_CARD_BORDER_EN
            ,
            .on_edge (edge_vec[g])
`endif
        );
    end

    logic             win_hit, win_face;
    logic [RGB_W-1:0] win_rgb;
`ifdef DRAW_CARD_BORDER_EN
    logic             win_edge;
`endif

    // Scan high to low so the lowest hitting index is the last to overwrite
    always_comb begin
        win_hit  = 1'b0;
        win_face = 1'b0;
        win_rgb  = '0;
`ifdef DRAW_CARD_BORDER_EN
        win_edge = 1'b0;
`endif
        for (int i = N_CARDS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                win_hit  = 1'b1;
                win_face = act_bank[i].card[CARD_FACE_BIT];
                win_rgb  = act_bank[i].card[CARD_RGB_LSB +: RGB_W];
`ifdef DRAW_CARD_BORDER_EN
                win_edge = edge_vec[i];
`endif
            end
        end
        if (!win_hit)
            pixel = rgb_in;
        else if (win_face)
            pixel = win_rgb;
        else
            pixel = COVERED_COLOR;
`ifdef DRAW_CARD_BORDER_EN
        if (win_hit && win_edge)
            pixel = BORDER_COLOR;
`endif
    end

endmodule

// File: tb/tb_draw_card_bank.sv
// tb/tb_draw_card_bank.sv - directed self-checking bench for draw_card_bank
module tb_draw_card_bank;
    import draw_card_bank_pkg::*;

    logic pclk = 1'b0;
    logic rst_n;
    always #5 pclk = ~pclk;

    logic        hs, vs, hblnk, vblnk;
    logic [10:0] hcount, vcount;
    logic [11:0] rgb;
    logic [VGA_BUS_SIZE-1:0] vga_in, vga_out;
    logic        rd_req, rd_valid, sync_done, load_miss;
    logic [1:0]  rd_idx;
    logic [13:0] rd_card;
    logic [19:0] rd_pos;

    int n_assert = 0;
    int n_fail   = 0;
    int n_sync   = 0;
    int n_miss   = 0;
    logic [13:0] tb_card [4];
    logic [19:0] tb_pos  [4];

    function automatic logic [VGA_BUS_SIZE-1:0] mk_bus(input logic h_s, v_s, hb, vb,
                                                       input logic [10:0] hc, vc,
                                                       input logic [11:0] px);
        logic [VGA_BUS_SIZE-1:0] b;
        b = '0;
        b[HS_BIT]    = h_s;
        b[VS_BIT]    = v_s;
        b[HBLNK_BIT] = hb;
        b[VBLNK_BIT] = vb;
        b[HCOUNT_LSB +: 11] = hc;
        b[VCOUNT_LSB +: 11] = vc;
        b[RGB_LSB +: 12]    = px;
        return b;
    endfunction

    assign vga_in = mk_bus(hs, vs, hblnk, vblnk, hcount, vcount, rgb);

    draw_card_bank dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .vga_in    (vga_in),
        .vga_out   (vga_out),
        .rd_req    (rd_req),
        .rd_idx    (rd_idx),
        .rd_valid  (rd_valid),
        .rd_card   (rd_card),
        .rd_pos    (rd_pos),
        .sync_done (sync_done),
        .load_miss (load_miss)
    );

    always @(negedge pclk) begin
        if (sync_done === 1'b1) n_sync++;
        if (load_miss === 1'b1) n_miss++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one pixel, then check the whole bus one cycle later
    task automatic pix(input string tag, input int h, input int v,
                       input logic [11:0] px, input logic [11:0] exp_rgb);
        hs = ~hs;
        hcount = 11'(h);
        vcount = 11'(v);
        rgb = px;
        @(posedge pclk); #1;
        chk(tag, 64'(vga_out), 64'(mk_bus(hs, vs, hblnk, vblnk, hcount, vcount, exp_rgb)));
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (rd_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge pclk); #1;
        end
        if (!ok) chk("rd_req_timeout", 64'd0, 64'd1);
    endtask

    // Serve one vblank load; abort_at < 4 drops vblnk when that word is requested
    task automatic do_load(input int delay, input int abort_at,
                           input int ph, input int pv, input logic [11:0] prgb,
                           input logic [11:0] old_exp, input logic [11:0] new_exp);
        bit ok;
        vblnk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_req(ok);
            if (!ok) begin
                vblnk = 1'b0;
                return;
            end
            chk($sformatf("rd_idx_%0d", i), 64'(rd_idx), 64'(i));
            if (i == abort_at) begin
                vblnk = 1'b0;
                @(posedge pclk); #1;
                chk("load_miss_pulse", 64'(load_miss), 64'd1);
                chk("no_sync_on_abort", 64'(sync_done), 64'd0);
                @(posedge pclk); #1;
                chk("load_miss_clear", 64'(load_miss), 64'd0);
                return;
            end
            rd_card = tb_card[i];
            rd_pos  = tb_pos[i];
            if (delay > 0) begin
                repeat (delay) @(posedge pclk);
                #1;
            end
            rd_valid = 1'b1;
            @(posedge pclk); #1;
            rd_valid = 1'b0;
        end
        chk("sync_done_commit", 64'(sync_done), 64'd1);
        pix("commit_cycle_old_bank", ph, pv, prgb, old_exp);
        pix("after_commit_new_bank", ph, pv, prgb, new_exp);
        chk("sync_done_single", 64'(sync_done), 64'd0);
        vblnk = 1'b0;
    endtask

    task automatic set_bank_a();
        tb_card[0] = {12'hF00, 2'b11}; tb_pos[0] = {10'd100, 10'd200};
        tb_card[1] = 14'h0001;         tb_pos[1] = {10'd0,   10'd0};
        tb_card[2] = {12'h0F0, 2'b11}; tb_pos[2] = {10'd700, 10'd900};
        tb_card[3] = {12'h0FF, 2'b10}; tb_pos[3] = {10'd400, 10'd500};
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0;
        hs = 1'b1; vs = 1'b1; hblnk = 1'b1; vblnk = 1'b0;
        hcount = 11'd5; vcount = 11'd6; rgb = 12'h321;
        rd_valid = 1'b0; rd_card = '0; rd_pos = '0;
        #2;
        chk("reset_vga_out", 64'(vga_out), 64'd0);
        chk("reset_rd_req", 64'(rd_req), 64'd0);
        chk("reset_rd_idx", 64'(rd_idx), 64'd0);
        chk("reset_sync_done", 64'(sync_done), 64'd0);
        chk("reset_load_miss", 64'(load_miss), 64'd0);
        @(negedge pclk) rst_n = 1'b1;
        hblnk = 1'b0; vs = 1'b0;
        @(posedge pclk); #1;
        pix("empty_bank", 250, 120, 12'h123, 12'h123);

        set_bank_a();
        do_load(0, 4, 250, 120, 12'h123, 12'h123, 12'hF00);
        pix("card0_inside", 250, 120, 12'h456, 12'hF00);
        pix("card0_left_of_x", 199, 120, 12'h456, 12'h456);
        pix("card0_far_corner", 263, 195, 12'h456, 12'hF00);
        pix("card0_right_out", 264, 120, 12'h456, 12'h456);
        pix("card0_below_out", 250, 196, 12'h456, 12'h456);
        pix("card1_face_down", 10, 10, 12'h456, 12'h0AA);
        pix("card3_state10_inactive", 510, 410, 12'h456, 12'h456);

        tb_card[0] = {12'hF00, 2'b11}; tb_pos[0] = {10'd280, 10'd280};
        tb_card[1] = 14'h0000;         tb_pos[1] = {10'd0,   10'd0};
        tb_card[2] = {12'h00F, 2'b11}; tb_pos[2] = {10'd290, 10'd290};
        tb_card[3] = {12'h0F0, 2'b11}; tb_pos[3] = {10'd0,   10'd1000};
        do_load(5, 4, 10, 10, 12'h555, 12'h0AA, 12'h555);
        pix("overlap_low_index_wins", 300, 300, 12'h111, 12'hF00);
        pix("card2_alone", 350, 300, 12'h111, 12'h00F);
        pix("card1_state00", 10, 10, 12'h111, 12'h111);
        pix("wide_x_last_col", 1063, 10, 12'h111, 12'h0F0);
        pix("wide_x_past_end", 1064, 10, 12'h111, 12'h111);

        tb_card[0] = {12'hABC, 2'b11}; tb_pos[0] = {10'd280, 10'd280};
        tb_card[1] = {12'hF0F, 2'b11}; tb_pos[1] = {10'd0,   10'd0};
        do_load(0, 2, 0, 0, 12'h0, 12'h0, 12'h0);
        pix("abort_keeps_card0", 300, 300, 12'h222, 12'hF00);
        pix("abort_keeps_card1", 10, 10, 12'h222, 12'h222);

        set_bank_a();
        vblnk = 1'b1;
        wait_req(ok);
        rd_card = tb_card[0]; rd_pos = tb_pos[0]; rd_valid = 1'b1;
        @(posedge pclk); #1;
        rd_valid = 1'b0;
        wait_req(ok);
        chk("pre_reset_rd_idx", 64'(rd_idx), 64'd1);
        repeat (2) @(posedge pclk);
        #1;
        rst_n = 1'b0;
        vblnk = 1'b0;
        #1;
        chk("midwait_reset_vga_out", 64'(vga_out), 64'd0);
        chk("midwait_reset_rd_req", 64'(rd_req), 64'd0);
        chk("midwait_reset_rd_idx", 64'(rd_idx), 64'd0);
        chk("midwait_reset_sync", 64'(sync_done), 64'd0);
        repeat (3) @(posedge pclk);
        #1;
        chk("midwait_reset_no_miss", 64'(load_miss), 64'd0);
        @(negedge pclk) rst_n = 1'b1;
        @(posedge pclk); #1;
        pix("banks_cleared", 300, 300, 12'h777, 12'h777);
        do_load(0, 4, 250, 120, 12'h777, 12'h777, 12'hF00);
`ifdef DRAW_CARD_BORDER_EN
        pix("card0_origin_border", 200, 100, 12'h777, 12'hFFF);
`else
        pix("card0_origin_no_border", 200, 100, 12'h777, 12'hF00);
`endif
        pix("reload_face_down", 30, 30, 12'h777, 12'h0AA);

        @(posedge pclk); #1;
        chk("sync_pulse_count", 64'(n_sync), 64'd3);
        chk("miss_pulse_count", 64'(n_miss), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
